// File: rtl/bcd_digit_conv_pkg.sv
// Shared definitions for the binary-to-BCD converter: overflow pattern,
// default range limit, FSM state encoding and the per-nibble correction.
package bcd_digit_conv_pkg;

  localparam logic [11:0] BCD_OVERFLOW_DIGITS = 12'hEEE;
  localparam int          BCD_MAX_VALUE       = 999;
  localparam int          BCD_CNT_W           = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } bcd_state_e;

  // Double-dabble correction: a nibble of 5 or more would exceed 9 once doubled.
  function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_conv_if.sv
// Bus between a value producer and the BCD converter; the converter is the slave.
interface bcd_digit_conv_if #(
  parameter int WIDTH = 10
);

  // Handshake: a value transfers on any rising edge where in_valid and in_ready
  // are both high; in_ready is a pure function of converter state, never of
  // in_valid. out_valid is a one-cycle pulse with no back-pressure, and
  // digits/overflow hold until the next completed result.
  logic [WIDTH-1:0] in_value;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      digits;
  logic             out_valid;
  logic             overflow;

  modport master (
    output in_value,
    output in_valid,
    input  in_ready,
    input  digits,
    input  out_valid,
    input  overflow
  );

  modport slave (
    input  in_value,
    input  in_valid,
    output in_ready,
    output digits,
    output out_valid,
    output overflow
  );

endinterface

// File: rtl/bcd_digit_conv_dabble_step.sv
// One double-dabble iteration on a 3-digit accumulator: add-3 correction on
// every nibble independently, then shift left taking shift_i into bit 0.
module bcd_dabble_step
  import bcd_digit_conv_pkg::*;
(
  input  logic [11:0] acc_i,
  input  logic        shift_i,
  output logic [11:0] acc_o
);

  logic [11:0] corr;

  always_comb begin
    corr  = {bcd_add3(acc_i[11:8]), bcd_add3(acc_i[7:4]), bcd_add3(acc_i[3:0])};
    acc_o = (corr << 1) | {11'b0, shift_i};
  end

endmodule

// File: rtl/bcd_digit_conv.sv
// Sequential binary-to-BCD converter feeding the 3-digit seven-segment driver.
// One input bit is consumed per clock; the displayed digits change only on completion.
module bcd_digit_conv
  import bcd_digit_conv_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_VALUE = BCD_MAX_VALUE
) (
  input  logic               clk,
  input  logic               rst,
  bcd_digit_conv_if.slave    bus,
  output bcd_state_e         state_o
);

  localparam logic [31:0]          MAX_U   = MAX_VALUE;
  localparam logic [BCD_CNT_W-1:0] CNT_TOP = BCD_CNT_W'(WIDTH);

  bcd_state_e           state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic [11:0]          acc_q, acc_d;
  logic [BCD_CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]          digits_q, digits_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                 in_ready;
  logic                 over_max;
  logic [11:0]          step_acc;

  assign in_ready = (state_q == ST_IDLE);
  assign over_max = (32'(bus.in_value) > MAX_U);

  bcd_dabble_step u_step (
    .acc_i   (acc_q),
    .shift_i (bin_q[WIDTH-1]),
    .acc_o   (step_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      digits_q    <= 12'h000;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (over_max) begin
            // Out-of-range values never enter the datapath; the error pattern is immediate.
            digits_d    = BCD_OVERFLOW_DIGITS;
            ovf_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            bin_d   = bus.in_value;
            acc_d   = 12'h000;
            cnt_d   = CNT_TOP;
            state_d = ST_CONV;
          end
        end
      end

      ST_CONV: begin
        acc_d = step_acc;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Publish the post-step accumulator so the result lands on the same edge.
          digits_d    = step_acc;
          ovf_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.digits    = digits_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = out_valid_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_bcd_digit_conv.sv
// Bench for bcd_digit_conv: a WIDTH=10 and a WIDTH=4 instance checked against a
// decimal reference model (division/modulo), with directed and random values.
module tb_bcd_digit_conv;
  import bcd_digit_conv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd_digit_conv_if #(.WIDTH(10)) bus_a ();
  bcd_digit_conv_if #(.WIDTH(4))  bus_b ();
  bcd_state_e st_a, st_b;

  bcd_digit_conv #(.WIDTH(10), .MAX_VALUE(999)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_o(st_a)
  );
  bcd_digit_conv #(.WIDTH(4), .MAX_VALUE(999)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .state_o(st_b)
  );

  // Reference: three decimal digits, or the error pattern above 999.
  function automatic logic [11:0] ref_digits(input int v);
    if (v > 999) return 12'hEEE;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int ref_latency(input bit sel, input int v);
    if (v > 999) return 0;
    return sel ? 4 : 10;
  endfunction

  function automatic logic ov_of(input bit sel);
    return sel ? bus_b.out_valid : bus_a.out_valid;
  endfunction

  function automatic logic rdy_of(input bit sel);
    return sel ? bus_b.in_ready : bus_a.in_ready;
  endfunction

  function automatic logic [11:0] dig_of(input bit sel);
    return sel ? bus_b.digits : bus_a.digits;
  endfunction

  function automatic logic ovf_of(input bit sel);
    return sel ? bus_b.overflow : bus_a.overflow;
  endfunction

  // Driver: present v, wait for the result. k = edges after the accept edge
  // at which out_valid was seen (40 means timeout).
  task automatic convert(input bit sel, input int v, output int k,
                         output logic [11:0] dg, output logic ovf,
                         output bit ready_ok, output bit single_ok);
    int guard = 0;
    while (!rdy_of(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sel) begin
      bus_b.in_value = 4'(v);
      bus_b.in_valid = 1'b1;
    end else begin
      bus_a.in_value = 10'(v);
      bus_a.in_valid = 1'b1;
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    k = 0; ready_ok = 1'b1; single_ok = 1'b0; dg = 12'hxxx; ovf = 1'bx;
    while (k < 40) begin
      if (ov_of(sel)) break;
      if (rdy_of(sel)) ready_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    if (k < 40) begin
      dg  = dig_of(sel);
      ovf = ovf_of(sel);
      @(negedge clk);
      single_ok = !ov_of(sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_value = '0;
    bus_b.in_valid = 1'b0; bus_b.in_value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus_a.digits !== 12'h000 || bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 ||
        bus_a.overflow !== 1'b0 || st_a !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_a digits=%h ov=%b rdy=%b ovf=%b st=%0d required 000/0/1/0/0",
               bus_a.digits, bus_a.out_valid, bus_a.in_ready, bus_a.overflow, st_a);
    end
    n_cmp++;
    if (bus_b.digits !== 12'h000 || bus_b.out_valid !== 1'b0 || bus_b.in_ready !== 1'b1 ||
        bus_b.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b digits=%h ov=%b rdy=%b ovf=%b required 000/0/1/0",
               bus_b.digits, bus_b.out_valid, bus_b.in_ready, bus_b.overflow);
    end
  endtask

  task automatic test_directed();
    int vals[6] = '{0, 999, 1000, 1023, 255, 500};
    int k;
    logic [11:0] dg;
    logic ovf;
    bit rok, sok;
    foreach (vals[i]) begin
      convert(1'b0, vals[i], k, dg, ovf, rok, sok);
      n_cmp++;
      if (k !== ref_latency(1'b0, vals[i])) begin
        n_err++;
        $display("FAIL dir_latency v=%0d got=%0d required=%0d", vals[i], k, ref_latency(1'b0, vals[i]));
      end
      n_cmp++;
      if (dg !== ref_digits(vals[i]) || ovf !== (vals[i] > 999)) begin
        n_err++;
        $display("FAIL dir_digits v=%0d got=%h/%b required=%h/%b", vals[i], dg, ovf,
                 ref_digits(vals[i]), vals[i] > 999);
      end
      n_cmp++;
      if (!rok || !sok) begin
        n_err++;
        $display("FAIL dir_ready_pulse v=%0d ready_low_ok=%0d single_pulse_ok=%0d required 1/1",
                 vals[i], rok, sok);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit saw_ready;
    while (!bus_a.in_ready) @(negedge clk);
    bus_a.in_value = 10'd123; bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_value = 10'd456;  // held valid throughout the conversion
    k = 0; saw_ready = 1'b0;
    while (k < 40 && !bus_a.out_valid) begin
      if (bus_a.in_ready) saw_ready = 1'b1;
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k !== 10 || bus_a.digits !== 12'h123 || saw_ready) begin
      n_err++;
      $display("FAIL b2b_first k=%0d digits=%h early_ready=%0d required 10/123/0", k, bus_a.digits, saw_ready);
    end
    n_cmp++;
    if (bus_a.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready_in_pulse got=%b required=1", bus_a.in_ready);
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    k = 0;
    while (k < 40 && !bus_a.out_valid) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k !== 10 || bus_a.digits !== 12'h456 || bus_a.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second k=%0d digits=%h ovf=%b required 10/456/0", k, bus_a.digits, bus_a.overflow);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [11:0] dg;
    logic ovf;
    bit rok, sok, pulse;
    convert(1'b0, 255, k, dg, ovf, rok, sok);
    n_cmp++;
    if (dg !== 12'h255) begin
      n_err++;
      $display("FAIL rmid_pre got=%h required=255", dg);
    end
    bus_a.in_value = 10'd807; bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus_a.digits !== 12'h000 || bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1 ||
        bus_a.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_after digits=%h ov=%b rdy=%b ovf=%b required 000/0/1/0",
               bus_a.digits, bus_a.out_valid, bus_a.in_ready, bus_a.overflow);
    end
    pulse = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus_a.out_valid) pulse = 1'b1;
    end
    n_cmp++;
    if (pulse) begin
      n_err++;
      $display("FAIL rmid_no_pulse got=1 required=0");
    end
    convert(1'b0, 42, k, dg, ovf, rok, sok);
    n_cmp++;
    if (dg !== 12'h042 || k !== 10) begin
      n_err++;
      $display("FAIL rmid_42 got=%h k=%0d required=042 k=10", dg, k);
    end
  endtask

  task automatic test_random();
    int v, k, gap;
    logic [11:0] dg;
    logic ovf;
    bit rok, sok;
    repeat (60) begin
      v = int'($urandom_range(0, 1023));
      convert(1'b0, v, k, dg, ovf, rok, sok);
      n_cmp++;
      if (k !== ref_latency(1'b0, v) || dg !== ref_digits(v) || ovf !== (v > 999) || !rok || !sok) begin
        n_err++;
        $display("FAIL rand v=%0d k=%0d digits=%h ovf=%b rok=%0d sok=%0d required k=%0d digits=%h ovf=%b",
                 v, k, dg, ovf, rok, sok, ref_latency(1'b0, v), ref_digits(v), v > 999);
      end
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      n_cmp++;
      if (bus_a.digits !== ref_digits(v) || bus_a.overflow !== (v > 999)) begin
        n_err++;
        $display("FAIL rand_hold v=%0d digits=%h ovf=%b required=%h/%b",
                 v, bus_a.digits, bus_a.overflow, ref_digits(v), v > 999);
      end
    end
  endtask

  task automatic test_sweep();
    int k;
    logic [11:0] dg;
    logic ovf;
    bit rok, sok;
    for (int v = 0; v < 1024; v++) begin
      convert(1'b0, v, k, dg, ovf, rok, sok);
      n_cmp++;
      if (k !== ref_latency(1'b0, v) || dg !== ref_digits(v) || ovf !== (v > 999)) begin
        n_err++;
        $display("FAIL sweep_w10 v=%0d k=%0d digits=%h ovf=%b required k=%0d digits=%h ovf=%b",
                 v, k, dg, ovf, ref_latency(1'b0, v), ref_digits(v), v > 999);
      end
    end
    for (int v = 0; v < 16; v++) begin
      convert(1'b1, v, k, dg, ovf, rok, sok);
      n_cmp++;
      if (k !== ref_latency(1'b1, v) || dg !== ref_digits(v) || ovf !== 1'b0 || !rok || !sok) begin
        n_err++;
        $display("FAIL sweep_w4 v=%0d k=%0d digits=%h ovf=%b rok=%0d sok=%0d required k=%0d digits=%h ovf=0",
                 v, k, dg, ovf, rok, sok, ref_latency(1'b1, v), ref_digits(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
